// File: rtl/fu_issue_seq.sv
// Issue sequencer for the 16-bit FU: owns the register file, PSR and PC, runs each
// micro-instruction as EXEC then INCPC. Optional macro FU_SEQ_ZERO_REG_EN hardwires R0 to zero.
module fu_issue_seq #(
    parameter int          NREGS    = 8,
    parameter int          RA_W     = 3,
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_opcode,
    input  logic [RA_W-1:0] req_rs,
    input  logic [RA_W-1:0] req_rt,
    input  logic [RA_W-1:0] req_rd,
    input  logic            req_imm_sel,
    input  logic [15:0]     req_imm,
    input  logic            req_setcc,
    output logic [15:0]     fu_a,
    output logic [15:0]     fu_b,
    output logic [3:0]      fu_opcode,
    input  logic [15:0]     fu_result,
    input  logic [3:0]      fu_status,
    output logic [3:0]      psr,
    output logic [15:0]     pc,
    output logic            done,
    input  logic [RA_W-1:0] dbg_addr,
    output logic [15:0]     dbg_data
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_EXEC  = 2'b01;
    localparam logic [1:0] S_INCPC = 2'b10;
    localparam logic [3:0] OP_INCPC = 4'b1111;

`ifdef FU_SEQ_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [1:0]      state_reg;
    logic [3:0]      op_reg;
    logic [RA_W-1:0] rd_reg;
    logic            setcc_reg;
    logic [15:0]     fu_a_reg;
    logic [15:0]     fu_b_reg;
    logic [3:0]      fu_op_reg;
    logic [3:0]      psr_reg;
    logic [15:0]     pc_reg;
    logic            done_reg;
    logic [15:0]     regs [NREGS];
    logic [NREGS-1:0] wr_en;
    logic            accept;
    logic            exec_live;

    assign accept    = (state_reg == S_IDLE) && req_valid;
    // The INCPC opcode doubles as a NOP: EXEC leaves registers and flags alone.
    assign exec_live = (state_reg == S_EXEC) && (op_reg != OP_INCPC);

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_wr_en
            assign wr_en[gi] = exec_live && (rd_reg == RA_W'(gi)) && !(ZERO_REG && (gi == 0));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= 16'h0000;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_en[i]) regs[i] <= fu_result;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            op_reg    <= 4'h0;
            rd_reg    <= '0;
            setcc_reg <= 1'b0;
            fu_a_reg  <= 16'h0000;
            fu_b_reg  <= 16'h0000;
            fu_op_reg <= 4'h0;
            psr_reg   <= 4'h0;
            pc_reg    <= PC_RESET;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= (state_reg == S_INCPC);
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        // Operands are sampled here so rd==rs/rt sees pre-write values.
                        op_reg    <= req_opcode;
                        rd_reg    <= req_rd;
                        setcc_reg <= req_setcc;
                        fu_a_reg  <= regs[req_rs];
                        fu_b_reg  <= req_imm_sel ? req_imm : regs[req_rt];
                        fu_op_reg <= req_opcode;
                        state_reg <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exec_live && setcc_reg) psr_reg <= fu_status;
                    fu_a_reg  <= pc_reg;
                    fu_b_reg  <= 16'h0000;
                    fu_op_reg <= OP_INCPC;
                    state_reg <= S_INCPC;
                end
                S_INCPC: begin
                    pc_reg    <= fu_result;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (state_reg == S_IDLE) && rst_n;
    assign fu_a      = fu_a_reg;
    assign fu_b      = fu_b_reg;
    assign fu_opcode = fu_op_reg;
    assign psr       = psr_reg;
    assign pc        = pc_reg;
    assign done      = done_reg;
    assign dbg_data  = regs[dbg_addr];

endmodule

// File: tb/tb_fu_issue_seq.sv
// Self-checking bench for fu_issue_seq: behavioural FU model, vector table, scoreboard queue.
module tb_fu_issue_seq;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [2:0]  rd;
        logic        imm_sel;
        logic [15:0] imm;
        logic        setcc;
        logic [15:0] exp_val;
        logic [3:0]  exp_psr;
        logic [15:0] exp_pc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst1_n, rst2_n;
    logic        req_valid;
    logic [3:0]  req_opcode;
    logic [2:0]  req_rs, req_rt, req_rd, dbg_addr;
    logic        req_imm_sel, req_setcc;
    logic [15:0] req_imm;

    logic        req_ready1, done1, req_ready2, done2;
    logic [15:0] fu_a1, fu_b1, fu_result1, pc1, dbg_data1;
    logic [15:0] fu_a2, fu_b2, fu_result2, pc2, dbg_data2;
    logic [3:0]  fu_opcode1, fu_status1, psr1, fu_opcode2, fu_status2, psr2;

    bit          sel;
    logic        ready_s, done_s;
    logic [15:0] pc_s, dbg_s;
    logic [3:0]  psr_s;

    int checks = 0;
    int errors = 0;
    vec_t sb[$];
    vec_t tbl[7];

    always #5 clk = ~clk;

    fu_issue_seq #(.NREGS(8), .RA_W(3), .PC_RESET(16'h0000)) dut1 (
        .clk(clk), .rst_n(rst1_n), .req_valid(req_valid), .req_ready(req_ready1),
        .req_opcode(req_opcode), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_imm_sel(req_imm_sel), .req_imm(req_imm), .req_setcc(req_setcc),
        .fu_a(fu_a1), .fu_b(fu_b1), .fu_opcode(fu_opcode1), .fu_result(fu_result1),
        .fu_status(fu_status1), .psr(psr1), .pc(pc1), .done(done1),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data1));

    fu_issue_seq #(.NREGS(8), .RA_W(3), .PC_RESET(16'hFFFE)) dut2 (
        .clk(clk), .rst_n(rst2_n), .req_valid(req_valid), .req_ready(req_ready2),
        .req_opcode(req_opcode), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_imm_sel(req_imm_sel), .req_imm(req_imm), .req_setcc(req_setcc),
        .fu_a(fu_a2), .fu_b(fu_b2), .fu_opcode(fu_opcode2), .fu_result(fu_result2),
        .fu_status(fu_status2), .psr(psr2), .pc(pc2), .done(done2),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data2));

    // Behavioural FU: returns {C,V,N,Z, result}
    function automatic logic [19:0] fu_model(input logic [3:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
        logic [16:0] s;
        logic        v;
        case (op)
            4'b0100: begin
                s = {1'b0, a} + {1'b0, b};
                v = (a[15] == b[15]) && (s[15] != a[15]);
            end
            4'b0101: begin
                s = {1'b0, a} + {1'b0, ~b} + 17'd1;
                v = (a[15] != b[15]) && (s[15] != a[15]);
            end
            4'b1111: begin
                s = {1'b0, a} + 17'd2;
                v = 1'b0;
            end
            default: begin
                s = {1'b0, a ^ b};
                v = 1'b0;
            end
        endcase
        return {s[16], v, s[15], (s[15:0] == 16'h0000), s[15:0]};
    endfunction

    always_comb {fu_status1, fu_result1} = fu_model(fu_opcode1, fu_a1, fu_b1);
    always_comb {fu_status2, fu_result2} = fu_model(fu_opcode2, fu_a2, fu_b2);

    assign ready_s = sel ? req_ready2 : req_ready1;
    assign done_s  = sel ? done2 : done1;
    assign pc_s    = sel ? pc2 : pc1;
    assign psr_s   = sel ? psr2 : psr1;
    assign dbg_s   = sel ? dbg_data2 : dbg_data1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req_opcode  = v.op;
        req_rs      = v.rs;
        req_rt      = v.rt;
        req_rd      = v.rd;
        req_imm_sel = v.imm_sel;
        req_imm     = v.imm;
        req_setcc   = v.setcc;
        req_valid   = 1'b1;
    endtask

    task automatic issue(input vec_t v);
        int   k;
        int   lat;
        vec_t e;
        k = 0;
        while (!ready_s && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("ready_wait", {15'b0, ready_s}, 16'h0001);
        drive(v);
        sb.push_back(v);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done_s && lat < 10);
        chk("latency", 16'(lat), 16'd3);
        e = sb.pop_front();
        chk("pc", pc_s, e.exp_pc);
        chk("psr", {12'b0, psr_s}, {12'b0, e.exp_psr});
        dbg_addr = e.rd;
        #1;
        chk("reg_rd", dbg_s, e.exp_val);
        $display("txn dut%0d op=%h rd=%0d val=%h psr=%b pc=%h lat=%0d",
                 sel ? 2 : 1, e.op, e.rd, dbg_s, psr_s, pc_s, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v2;
        //          op     rs    rt    rd    isel  imm       setcc exp_val   psr      pc
        tbl[0] = '{4'h4, 3'd0, 3'd0, 3'd1, 1'b1, 16'h7FFF, 1'b0, 16'h7FFF, 4'b0000, 16'h0002};
        tbl[1] = '{4'h4, 3'd1, 3'd0, 3'd2, 1'b1, 16'h0001, 1'b1, 16'h8000, 4'b0110, 16'h0004};
        tbl[2] = '{4'h5, 3'd2, 3'd2, 3'd3, 1'b0, 16'h0000, 1'b1, 16'h0000, 4'b1001, 16'h0006};
        tbl[3] = '{4'hF, 3'd1, 3'd1, 3'd3, 1'b0, 16'h0000, 1'b1, 16'h0000, 4'b1001, 16'h0008};
`ifdef FU_SEQ_ZERO_REG_EN
        tbl[4] = '{4'h4, 3'd0, 3'd0, 3'd0, 1'b1, 16'h1234, 1'b0, 16'h0000, 4'b1001, 16'h000A};
`else
        tbl[4] = '{4'h4, 3'd0, 3'd0, 3'd0, 1'b1, 16'h1234, 1'b0, 16'h1234, 4'b1001, 16'h000A};
`endif
        tbl[5] = '{4'h4, 3'd1, 3'd1, 3'd1, 1'b0, 16'h0000, 1'b1, 16'hFFFE, 4'b0110, 16'h000C};
        tbl[6] = '{4'h5, 3'd3, 3'd0, 3'd4, 1'b1, 16'h0001, 1'b1, 16'hFFFF, 4'b0010, 16'h000E};

        rst1_n = 1'b0; rst2_n = 1'b0; sel = 1'b0;
        req_valid = 1'b0; req_opcode = 4'h0; req_rs = '0; req_rt = '0; req_rd = '0;
        req_imm_sel = 1'b0; req_imm = 16'h0; req_setcc = 1'b0; dbg_addr = 3'd1;

        repeat (2) @(negedge clk);
        chk("rst_ready", {15'b0, req_ready1}, 16'h0000);
        chk("rst_done", {15'b0, done1}, 16'h0000);
        chk("rst_pc", pc1, 16'h0000);
        chk("rst_psr", {12'b0, psr1}, 16'h0000);
        chk("rst_fu_a", fu_a1, 16'h0000);
        chk("rst_fu_b", fu_b1, 16'h0000);
        chk("rst_fu_op", {12'b0, fu_opcode1}, 16'h0000);
        chk("rst_reg1", dbg_data1, 16'h0000);
        chk("rst_pc2", pc2, 16'hFFFE);
        rst1_n = 1'b1;
        #1 chk("ready_after_rst", {15'b0, req_ready1}, 16'h0001);
        @(negedge clk);

        // Back-to-back issue: each new request lands in the done cycle of the previous one.
        for (int i = 0; i < 7; i++) issue(tbl[i]);

        @(negedge clk);
        chk("done_one_cycle", {15'b0, done1}, 16'h0000);
        repeat (3) @(negedge clk);
        chk("pc_idle_hold", pc1, 16'h000E);
        rst1_n = 1'b0;

        // Second instance: PC wraps from 16'hFFFE.
        sel = 1'b1;
        rst2_n = 1'b1;
        @(negedge clk);
        v2 = '{4'h4, 3'd0, 3'd0, 3'd6, 1'b1, 16'h0005, 1'b0, 16'h0005, 4'b0000, 16'h0000};
        issue(v2);

        // Reset arriving during EXEC aborts the instruction.
        v2 = '{4'h4, 3'd0, 3'd0, 3'd5, 1'b1, 16'hABCD, 1'b1, 16'hABCD, 4'b0000, 16'h0002};
        drive(v2);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("exec_fu_b", fu_b2, 16'hABCD);
        chk("exec_fu_op", {12'b0, fu_opcode2}, 16'h0004);
        rst2_n = 1'b0;
        dbg_addr = 3'd5;
        #1;
        chk("abort_ready", {15'b0, ready_s}, 16'h0000);
        chk("abort_pc", pc_s, 16'hFFFE);
        chk("abort_psr", {12'b0, psr_s}, 16'h0000);
        chk("abort_reg5", dbg_s, 16'h0000);
        dbg_addr = 3'd6;
        #1 chk("abort_reg6_cleared", dbg_s, 16'h0000);
        @(negedge clk);
        rst2_n = 1'b1;
        #1 chk("abort_ready_release", {15'b0, ready_s}, 16'h0001);
        repeat (3) @(negedge clk);
        chk("abort_pc_hold", pc_s, 16'hFFFE);
        chk("abort_no_done", {15'b0, done_s}, 16'h0000);
        dbg_addr = 3'd5;
        #1 chk("abort_no_wb", dbg_s, 16'h0000);
        $display("txn dut2 reset-in-exec pc=%h psr=%b", pc_s, psr_s);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
